// File: rtl/ttt_game_controller.sv
// Two-player move sequencer for the 3x3 TBox board. It serves the in-turn player,
// validates each move against the board's valid bits, drives TBox set/row/col/reset,
// enforces a per-move timeout and keeps saturating win/draw tallies.
module ttt_game_controller #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SCORE_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_x,
    input  logic [1:0]         row_x,
    input  logic [1:0]         col_x,
    input  logic               req_o,
    input  logic [1:0]         row_o,
    input  logic [1:0]         col_o,
    input  logic               new_game,
    output logic               ack_x,
    output logic               ack_o,
    output logic               nack_x,
    output logic               nack_o,
    output logic               tb_set,
    output logic [1:0]         tb_row,
    output logic [1:0]         tb_col,
    output logic               tb_reset,
    input  logic [8:0]         board_valid,
    input  logic [1:0]         game_state,
    output logic               turn,
    output logic [1:0]         result,
    output logic               timeout,
    output logic [SCORE_W-1:0] score_x,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] draws
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        ST_CLEAR, ST_WAIT, ST_ISSUE, ST_SETTLE, ST_CHECK, ST_OVER
    } state_t;

    state_t             state_reg, state_next;
    logic               turn_reg, turn_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [1:0]         result_reg, result_next;
    logic [SCORE_W-1:0] score_x_reg, score_x_next;
    logic [SCORE_W-1:0] score_o_reg, score_o_next;
    logic [SCORE_W-1:0] draws_reg, draws_next;
    logic [1:0]         row_reg, row_next;
    logic [1:0]         col_reg, col_next;
    logic               nack_x_reg, nack_x_next;
    logic               nack_o_reg, nack_o_next;
    logic               timeout_reg, timeout_next;

    logic               mv_req;
    logic [1:0]         mv_row;
    logic [1:0]         mv_col;
    logic [8:0]         req_mask;
    logic [8:0]         lat_mask;
    logic               legal;
    logic               placed;
    logic               active;
    logic               holds_cell;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

    // Select the request of the player whose turn it is; the other one is simply held off.
    always_comb begin
        mv_req = turn_reg ? req_x : req_o;
        mv_row = turn_reg ? row_x : row_o;
        mv_col = turn_reg ? col_x : col_o;
    end

    // One-hot cell decode for the requested cell and for the latched cell being placed.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign req_mask[gi] = (mv_row == 2'(gi / 3 + 1)) && (mv_col == 2'(gi % 3 + 1));
            assign lat_mask[gi] = (row_reg == 2'(gi / 3 + 1)) && (col_reg == 2'(gi % 3 + 1));
        end
    endgenerate

    assign legal  = mv_req && (mv_row != 2'd0) && (mv_col != 2'd0)
                    && ((board_valid & req_mask) == 9'd0);
    assign placed = (board_valid & lat_mask) != 9'd0;

    // Next-state and next-value logic for the move sequencer.
    always_comb begin
        state_next   = state_reg;
        turn_next    = turn_reg;
        timer_next   = timer_reg;
        result_next  = result_reg;
        score_x_next = score_x_reg;
        score_o_next = score_o_reg;
        draws_next   = draws_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        nack_x_next  = 1'b0;
        nack_o_next  = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                turn_next   = 1'b1;
                timer_next  = '0;
                result_next = 2'b00;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (legal) begin
                    // A legal move in the expiry cycle takes priority over the forfeit.
                    row_next   = mv_row;
                    col_next   = mv_col;
                    state_next = ST_ISSUE;
                end else if (timer_reg == TIMER_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_OVER;
                    if (turn_reg) begin
                        result_next  = 2'b10;
                        score_o_next = sat_inc(score_o_reg);
                    end else begin
                        result_next  = 2'b01;
                        score_x_next = sat_inc(score_x_reg);
                    end
                end else begin
                    timer_next  = timer_reg + 1'b1;
                    nack_x_next = mv_req && turn_reg;
                    nack_o_next = mv_req && !turn_reg;
                end
            end
            ST_ISSUE:  state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_CHECK;
            ST_CHECK: begin
                if (!placed) begin
                    state_next = ST_WAIT;
                end else if (game_state == 2'b00) begin
                    turn_next  = !turn_reg;
                    timer_next = '0;
                    state_next = ST_WAIT;
                end else begin
                    result_next = game_state;
                    state_next  = ST_OVER;
                    case (game_state)
                        2'b01:   score_x_next = sat_inc(score_x_reg);
                        2'b10:   score_o_next = sat_inc(score_o_reg);
                        default: draws_next   = sat_inc(draws_reg);
                    endcase
                end
            end
            ST_OVER: begin
                if (new_game) state_next = ST_CLEAR;
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            turn_reg    <= 1'b1;
            timer_reg   <= '0;
            result_reg  <= 2'b00;
            score_x_reg <= '0;
            score_o_reg <= '0;
            draws_reg   <= '0;
            row_reg     <= 2'd0;
            col_reg     <= 2'd0;
            nack_x_reg  <= 1'b0;
            nack_o_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            turn_reg    <= turn_next;
            timer_reg   <= timer_next;
            result_reg  <= result_next;
            score_x_reg <= score_x_next;
            score_o_reg <= score_o_next;
            draws_reg   <= draws_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            nack_x_reg  <= nack_x_next;
            nack_o_reg  <= nack_o_next;
            timeout_reg <= timeout_next;
        end
    end

    // Reset aborts immediately: every pulse and board command is masked while it is high.
    assign active     = !reset;
    assign holds_cell = active && ((state_reg == ST_ISSUE) || (state_reg == ST_SETTLE)
                                   || (state_reg == ST_CHECK));

    assign ack_x    = active && (state_reg == ST_CHECK) && placed && turn_reg;
    assign ack_o    = active && (state_reg == ST_CHECK) && placed && !turn_reg;
    assign nack_x   = active && (nack_x_reg || ((state_reg == ST_CHECK) && !placed && turn_reg));
    assign nack_o   = active && (nack_o_reg || ((state_reg == ST_CHECK) && !placed && !turn_reg));
    assign tb_set   = active && (state_reg == ST_ISSUE);
    assign tb_reset = active && (state_reg == ST_CLEAR);
    assign tb_row   = holds_cell ? row_reg : 2'd0;
    assign tb_col   = holds_cell ? col_reg : 2'd0;
    assign timeout  = active && timeout_reg;
    assign turn     = turn_reg;
    assign result   = result_reg;
    assign score_x  = score_x_reg;
    assign score_o  = score_o_reg;
    assign draws    = draws_reg;
endmodule

// File: tb/tb_ttt_game_controller.sv
// Directed bench for ttt_game_controller with a behavioural TBox board model and a
// queue of expected move responses.
module tb_ttt_game_controller;
    localparam int TO = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_x, req_o, new_game;
    logic [1:0]    row_x, col_x, row_o, col_o;
    logic          ack_x, ack_o, nack_x, nack_o;
    logic          tb_set, tb_reset;
    logic [1:0]    tb_row, tb_col;
    logic [8:0]    board_valid;
    logic [1:0]    game_state;
    logic          turn, timeout;
    logic [1:0]    result;
    logic [SW-1:0] score_x, score_o, draws;

    always #5 clk = ~clk;

    ttt_game_controller #(.TIMEOUT_CYCLES(TO), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset),
        .req_x(req_x), .row_x(row_x), .col_x(col_x),
        .req_o(req_o), .row_o(row_o), .col_o(col_o),
        .new_game(new_game),
        .ack_x(ack_x), .ack_o(ack_o), .nack_x(nack_x), .nack_o(nack_o),
        .tb_set(tb_set), .tb_row(tb_row), .tb_col(tb_col), .tb_reset(tb_reset),
        .board_valid(board_valid), .game_state(game_state),
        .turn(turn), .result(result), .timeout(timeout),
        .score_x(score_x), .score_o(score_o), .draws(draws)
    );

    // ---------------- TBox model ----------------
    logic [17:0] own;
    int          sym_cnt;

    function automatic int cell_idx(input logic [1:0] r, input logic [1:0] c);
        return (int'(r) - 1) * 3 + (int'(c) - 1);
    endfunction

    function automatic logic [1:0] line3(input logic [8:0] v, input logic [17:0] o,
                                         input int a, input int b, input int c);
        if (v[a] && v[b] && v[c] && (o[2*a +: 2] == o[2*b +: 2]) && (o[2*a +: 2] == o[2*c +: 2]))
            return o[2*a +: 2];
        return 2'b00;
    endfunction

    function automatic logic [1:0] eval_board(input logic [8:0] v, input logic [17:0] o);
        logic [1:0] w;
        w = line3(v, o, 0, 1, 2);
        if (w == 2'b00) w = line3(v, o, 3, 4, 5);
        if (w == 2'b00) w = line3(v, o, 6, 7, 8);
        if (w == 2'b00) w = line3(v, o, 0, 3, 6);
        if (w == 2'b00) w = line3(v, o, 1, 4, 7);
        if (w == 2'b00) w = line3(v, o, 2, 5, 8);
        if (w == 2'b00) w = line3(v, o, 0, 4, 8);
        if (w == 2'b00) w = line3(v, o, 2, 4, 6);
        if (w == 2'b00 && (&v)) w = 2'b11;
        return w;
    endfunction

    always @(posedge clk) begin
        if (reset || tb_reset) begin
            board_valid <= 9'd0;
            own         <= 18'd0;
            sym_cnt     <= 0;
        end else if (tb_set && tb_row != 2'd0 && tb_col != 2'd0
                     && !board_valid[cell_idx(tb_row, tb_col)]) begin
            board_valid[cell_idx(tb_row, tb_col)]  <= 1'b1;
            own[2*cell_idx(tb_row, tb_col) +: 2]   <= (sym_cnt % 2 == 0) ? 2'b01 : 2'b10;
            sym_cnt                                <= sym_cnt + 1;
        end
    end

    always_comb game_state = eval_board(board_valid, own);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit exp_turn = 1'b1;

    typedef struct {
        int kind;      // 0 none, 1 ack, 2 nack
        int lat;
        int set_seen;
        int row;
        int col;
        int stray;
    } resp_t;

    resp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_move(input bit is_x, input int r, input int c, input int exp_kind,
                           input bit flip, input string tag);
        resp_t e;
        resp_t o;
        @(negedge clk);
        check({tag, ".turn"}, 32'(turn), 32'(exp_turn));
        e.kind     = exp_kind;
        e.lat      = (exp_kind == 1) ? 3 : ((exp_kind == 2) ? 1 : 0);
        e.set_seen = (exp_kind == 1) ? 1 : 0;
        e.row      = (exp_kind == 1) ? r : 0;
        e.col      = (exp_kind == 1) ? c : 0;
        e.stray    = 0;
        exp_q.push_back(e);
        o.kind = 0; o.lat = 0; o.set_seen = 0; o.row = 0; o.col = 0; o.stray = 0;
        if (is_x) begin
            req_x = 1'b1; row_x = 2'(r); col_x = 2'(c);
        end else begin
            req_o = 1'b1; row_o = 2'(r); col_o = 2'(c);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (tb_set) begin
                o.set_seen = 1; o.row = int'(tb_row); o.col = int'(tb_col);
            end
            if (is_x ? (ack_o || nack_o) : (ack_x || nack_x)) o.stray++;
            if (is_x ? ack_x : ack_o) begin
                o.kind = 1; o.lat = k; break;
            end
            if (is_x ? nack_x : nack_o) begin
                o.kind = 2; o.lat = k; break;
            end
        end
        if (is_x) req_x = 1'b0; else req_o = 1'b0;
        e = exp_q.pop_front();
        check({tag, ".kind"},  32'(o.kind),     32'(e.kind));
        check({tag, ".lat"},   32'(o.lat),      32'(e.lat));
        check({tag, ".set"},   32'(o.set_seen), 32'(e.set_seen));
        check({tag, ".row"},   32'(o.row),      32'(e.row));
        check({tag, ".col"},   32'(o.col),      32'(e.col));
        check({tag, ".stray"}, 32'(o.stray),    32'(e.stray));
        $display("move %s player=%s cell=(%0d,%0d) response=%0d latency=%0d",
                 tag, is_x ? "X" : "O", r, c, o.kind, o.lat);
        if (exp_kind == 1 && flip) exp_turn = ~exp_turn;
    endtask

    task automatic start_new_game(input string tag);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check({tag, ".tb_reset_on"}, 32'(tb_reset), 32'd1);
        @(negedge clk);
        check({tag, ".tb_reset_off"}, 32'(tb_reset), 32'd0);
        check({tag, ".turn"}, 32'(turn), 32'd1);
        check({tag, ".result"}, 32'(result), 32'd0);
        exp_turn = 1'b1;
        $display("new game %s", tag);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1; req_x = 1'b0; req_o = 1'b0; new_game = 1'b0;
        row_x = 2'd0; col_x = 2'd0; row_o = 2'd0; col_o = 2'd0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.turn",     32'(turn),     32'd1);
        check("rst.result",   32'(result),   32'd0);
        check("rst.score_x",  32'(score_x),  32'd0);
        check("rst.score_o",  32'(score_o),  32'd0);
        check("rst.draws",    32'(draws),    32'd0);
        check("rst.tb_reset", 32'(tb_reset), 32'd0);
        check("rst.tb_set",   32'(tb_set),   32'd0);
        check("rst.tb_row",   32'(tb_row),   32'd0);
        check("rst.timeout",  32'(timeout),  32'd0);
        reset = 1'b0;
        #1;
        check("clear.tb_reset", 32'(tb_reset), 32'd1);

        // Game 1: X wins on the top row, with illegal X requests in the middle
        do_move(1'b1, 1, 1, 1, 1'b1, "g1.x11");
        do_move(1'b0, 2, 1, 1, 1'b1, "g1.o21");
        do_move(1'b1, 1, 1, 2, 1'b0, "g1.x11_occupied");
        do_move(1'b1, 0, 2, 2, 1'b0, "g1.x_row0");
        do_move(1'b1, 1, 2, 1, 1'b1, "g1.x12");
        do_move(1'b0, 2, 2, 1, 1'b1, "g1.o22");
        do_move(1'b1, 1, 3, 1, 1'b0, "g1.x13_win");
        @(negedge clk);
        check("g1.result",  32'(result),  32'd1);
        check("g1.score_x", 32'(score_x), 32'd1);
        check("g1.score_o", 32'(score_o), 32'd0);
        do_move(1'b1, 3, 3, 0, 1'b0, "g1.over_x");
        do_move(1'b0, 3, 3, 0, 1'b0, "g1.over_o");
        check("g1.result_held", 32'(result), 32'd1);

        // Game 2: O requests out of turn, then X idles into a forfeit
        start_new_game("g2");
        req_o = 1'b1; row_o = 2'd3; col_o = 2'd3;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack_o || nack_o) cnt++;
        end
        check("g2.o_out_of_turn", 32'(cnt), 32'd0);
        do_move(1'b1, 1, 1, 1, 1'b1, "g2.x11");
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ack_o) begin
                cnt = k; break;
            end
        end
        req_o = 1'b0;
        check("g2.o_served_lat", 32'(cnt), 32'd4);
        exp_turn = 1'b1;
        $display("move g2.o33 player=O cell=(3,3) latency_after_x_ack=%0d", cnt);
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (timeout) begin
                cnt = k; break;
            end
        end
        check("g2.timeout_lat", 32'(cnt),     32'd9);
        check("g2.result",      32'(result),  32'd2);
        check("g2.score_o",     32'(score_o), 32'd1);
        check("g2.score_x",     32'(score_x), 32'd1);
        @(negedge clk);
        check("g2.timeout_pulse", 32'(timeout), 32'd0);
        $display("timeout g2 after %0d cycles", cnt);

        // Game 3: nine moves with no line -> draw
        start_new_game("g3");
        do_move(1'b1, 1, 1, 1, 1'b1, "g3.m1");
        do_move(1'b0, 1, 2, 1, 1'b1, "g3.m2");
        do_move(1'b1, 1, 3, 1, 1'b1, "g3.m3");
        do_move(1'b0, 2, 2, 1, 1'b1, "g3.m4");
        do_move(1'b1, 2, 1, 1, 1'b1, "g3.m5");
        do_move(1'b0, 2, 3, 1, 1'b1, "g3.m6");
        do_move(1'b1, 3, 2, 1, 1'b1, "g3.m7");
        do_move(1'b0, 3, 1, 1, 1'b1, "g3.m8");
        do_move(1'b1, 3, 3, 1, 1'b0, "g3.m9");
        @(negedge clk);
        check("g3.result", 32'(result), 32'd3);
        check("g3.draws",  32'(draws),  32'd1);
        start_new_game("g4");

        // Reset while tb_set is high aborts the move
        req_x = 1'b1; row_x = 2'd1; col_x = 2'd1;
        @(negedge clk);
        check("rstmid.tb_set", 32'(tb_set), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid.ack_same", 32'(ack_x), 32'd0);
        @(negedge clk);
        check("rstmid.ack",     32'(ack_x),   32'd0);
        check("rstmid.tb_set2", 32'(tb_set),  32'd0);
        check("rstmid.tb_row",  32'(tb_row),  32'd0);
        check("rstmid.turn",    32'(turn),    32'd1);
        check("rstmid.result",  32'(result),  32'd0);
        check("rstmid.score_x", 32'(score_x), 32'd0);
        check("rstmid.score_o", 32'(score_o), 32'd0);
        check("rstmid.draws",   32'(draws),   32'd0);
        req_x = 1'b0;
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack_x || nack_x) cnt++;
        end
        check("rstmid.no_resp", 32'(cnt), 32'd0);
        exp_turn = 1'b1;
        $display("reset during move issue");

        // Four X wins with a 2-bit tally: saturates at 3
        for (int g = 0; g < 4; g++) begin
            if (g > 0) start_new_game("sat");
            do_move(1'b1, 1, 1, 1, 1'b1, "sat.x11");
            do_move(1'b0, 2, 1, 1, 1'b1, "sat.o21");
            do_move(1'b1, 1, 2, 1, 1'b1, "sat.x12");
            do_move(1'b0, 2, 2, 1, 1'b1, "sat.o22");
            do_move(1'b1, 1, 3, 1, 1'b0, "sat.x13");
            @(negedge clk);
            check("sat.result",  32'(result),  32'd1);
            check("sat.score_x", 32'(score_x), 32'((g + 1 > 3) ? 3 : g + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
